// File: rtl/indent_lexer.sv
// Indentation-aware front end: turns a character stream into CHAR/NEWLINE/INDENT/DEDENT/EOF tokens.
// Leading spaces set the target level; level changes are emitted as INDENT/DEDENT before the first char.
module indent_lexer #(
    parameter int INDENT_WIDTH = 4,
    parameter int MAX_LEVEL    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_kind,
    output logic [7:0] out_data,
    output logic [3:0] level,
    output logic       err
);
    localparam int CW = $clog2((MAX_LEVEL + 1) * INDENT_WIDTH + 1) + 1;
    localparam logic [CW-1:0] IW      = CW'(INDENT_WIDTH);
    localparam logic [CW-1:0] ML      = CW'(MAX_LEVEL);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [2:0] K_CHAR   = 3'd0;
    localparam logic [2:0] K_NL     = 3'd1;
    localparam logic [2:0] K_INDENT = 3'd2;
    localparam logic [2:0] K_DEDENT = 3'd3;
    localparam logic [2:0] K_EOF    = 3'd4;

    typedef enum logic [2:0] {
        ST_BOL    = 3'd0,
        ST_ADJUST = 3'd1,
        ST_BODY   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t        state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [3:0]    level_r, level_n_s;
    logic          out_valid_r, out_valid_n;
    logic [2:0]    out_kind_r, out_kind_n;
    logic [7:0]    out_data_r, out_data_n;
    logic          err_r, err_n;
    logic          pend_nl_r, pend_nl_n;
    logic          pend_eof_r, pend_eof_n;
    logic          run_r;

    logic          hold_s, free_s, take_s, is_space_s, is_nl_s;
    logic          misalign_s, too_deep_s, in_ready_s;
    logic [CW-1:0] target_s;
    logic          emit_s;
    logic [2:0]    emit_kind_s;
    logic [7:0]    emit_data_s;

    assign take_s     = out_valid_r & out_ready;
    assign hold_s     = out_valid_r & ~out_ready;
    assign free_s     = ~hold_s;
    assign is_space_s = (in_data == 8'h20);
    assign is_nl_s    = (in_data == 8'h0A);
    assign target_s   = cnt_r / IW;
    assign misalign_s = ((cnt_r % IW) != {CW{1'b0}});
    assign too_deep_s = (target_s > ML);

    // Committed level after this edge: INDENT/DEDENT count only once the consumer takes them.
    always_comb begin
        level_n_s = level_r;
        if (take_s && out_kind_r == K_INDENT) begin
            level_n_s = level_r + 4'd1;
        end else if (take_s && out_kind_r == K_DEDENT) begin
            level_n_s = level_r - 4'd1;
        end else begin
            level_n_s = level_r;
        end
    end

    // Next-state and token selection; in_ready depends on in_data because a char needing
    // INDENT/DEDENT first must be refused, not buffered.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        pend_nl_n   = pend_nl_r;
        pend_eof_n  = pend_eof_r;
        err_n       = err_r;
        emit_s      = 1'b0;
        emit_kind_s = K_CHAR;
        emit_data_s = 8'h00;
        in_ready_s  = 1'b0;
        case (state_r)
            ST_BOL: begin
                if (run_r && in_valid) begin
                    if (is_space_s || is_nl_s) begin
                        if (free_s) begin
                            in_ready_s = 1'b1;
                            if (in_last) begin
                                emit_s      = 1'b1;
                                emit_kind_s = K_EOF;
                                state_n     = ST_DONE;
                            end else if (is_space_s) begin
                                cnt_n = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                            end else begin
                                cnt_n = {CW{1'b0}};
                            end
                        end else begin
                            in_ready_s = 1'b0;
                        end
                    end else if (misalign_s || too_deep_s) begin
                        state_n = ST_ERROR;
                    end else if (target_s == CW'(level_r)) begin
                        if (free_s) begin
                            in_ready_s  = 1'b1;
                            emit_s      = 1'b1;
                            emit_kind_s = K_CHAR;
                            emit_data_s = in_data;
                            pend_nl_n   = in_last;
                            pend_eof_n  = in_last;
                            state_n     = ST_BODY;
                        end else begin
                            in_ready_s = 1'b0;
                        end
                    end else begin
                        state_n = ST_ADJUST;
                    end
                end else begin
                    in_ready_s = 1'b0;
                end
            end
            ST_ADJUST: begin
                if (!free_s) begin
                    state_n = ST_ADJUST;
                end else if (CW'(level_n_s) == target_s) begin
                    state_n = ST_BOL;
                end else if (target_s > CW'(level_n_s)) begin
                    emit_s      = 1'b1;
                    emit_kind_s = K_INDENT;
                end else begin
                    emit_s      = 1'b1;
                    emit_kind_s = K_DEDENT;
                end
            end
            ST_BODY: begin
                if (pend_nl_r) begin
                    if (free_s) begin
                        emit_s      = 1'b1;
                        emit_kind_s = K_NL;
                        pend_nl_n   = 1'b0;
                    end else begin
                        pend_nl_n = 1'b1;
                    end
                end else if (pend_eof_r) begin
                    if (free_s) begin
                        emit_s      = 1'b1;
                        emit_kind_s = K_EOF;
                        pend_eof_n  = 1'b0;
                        state_n     = ST_DONE;
                    end else begin
                        pend_eof_n = 1'b1;
                    end
                end else if (in_valid && free_s) begin
                    in_ready_s = 1'b1;
                    emit_s     = 1'b1;
                    if (is_nl_s) begin
                        emit_kind_s = K_NL;
                        cnt_n       = {CW{1'b0}};
                        pend_eof_n  = in_last;
                        state_n     = in_last ? ST_BODY : ST_BOL;
                    end else begin
                        emit_kind_s = K_CHAR;
                        emit_data_s = in_data;
                        pend_nl_n   = in_last;
                        pend_eof_n  = in_last;
                    end
                end else begin
                    in_ready_s = 1'b0;
                end
            end
            ST_DONE: begin
                state_n = ST_DONE;
            end
            ST_ERROR: begin
                err_n = 1'b1;
            end
            default: begin
                state_n = ST_ERROR;
            end
        endcase
    end

    // Output register staging: a stalled token is held; entering ERROR drops everything pending.
    always_comb begin
        out_valid_n = hold_s;
        out_kind_n  = out_kind_r;
        out_data_n  = out_data_r;
        if (state_n == ST_ERROR) begin
            out_valid_n = 1'b0;
            err_n_guard();
        end else if (emit_s) begin
            out_valid_n = 1'b1;
            out_kind_n  = emit_kind_s;
            out_data_n  = emit_data_s;
        end else begin
            out_valid_n = hold_s;
        end
    end

    function automatic void err_n_guard();
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_BOL;
            cnt_r       <= {CW{1'b0}};
            level_r     <= 4'd0;
            out_valid_r <= 1'b0;
            out_kind_r  <= 3'd0;
            out_data_r  <= 8'h00;
            err_r       <= 1'b0;
            pend_nl_r   <= 1'b0;
            pend_eof_r  <= 1'b0;
            run_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            level_r     <= level_n_s;
            out_valid_r <= out_valid_n;
            out_kind_r  <= out_kind_n;
            out_data_r  <= out_data_n;
            err_r       <= (state_n == ST_ERROR) ? 1'b1 : err_n;
            pend_nl_r   <= (state_n == ST_ERROR) ? 1'b0 : pend_nl_n;
            pend_eof_r  <= (state_n == ST_ERROR) ? 1'b0 : pend_eof_n;
            run_r       <= 1'b1;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_kind  = out_kind_r;
    assign out_data  = out_data_r;
    assign level     = level_r;
    assign err       = err_r;
endmodule

// File: tb/tb_indent_lexer.sv
// Directed bench for indent_lexer: table of source texts with hand-derived token strings,
// plus hand sequences for latency, indentation errors and reset during ADJUST.
module tb_indent_lexer;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_last, out_valid, out_ready, err;
    logic [7:0] in_data, out_data;
    logic [2:0] out_kind;
    logic [3:0] level;

    int checks = 0;
    int failures = 0;
    byte got_q[$];

    typedef struct {
        string name;
        string txt;
        string exp;   // '|' NEWLINE, '>' INDENT, '<' DEDENT, '$' EOF, anything else CHAR
        int    lvl;
        int    mode;  // 0: out_ready always 1, 1: out_ready 1-of-3 cycles
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    indent_lexer #(.INDENT_WIDTH(4), .MAX_LEVEL(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_data(out_data),
        .level(level), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic byte tok_char(input logic [2:0] k, input logic [7:0] d);
        case (k)
            3'd0:    return byte'(d);
            3'd1:    return 8'h7C;
            3'd2:    return 8'h3E;
            3'd3:    return 8'h3C;
            3'd4:    return 8'h24;
            default: return 8'h3F;
        endcase
    endfunction

    task automatic add_vec(input string name, input string txt, input string exp, input int lvl, input int mode);
        vec_t v;
        v.name = name; v.txt = txt; v.exp = exp; v.lvl = lvl; v.mode = mode;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_char(input byte c, input bit last, input int budget, output bit acc);
        acc = 1'b0;
        for (int n = 0; n < budget && !acc; n++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = c; in_last = last;
            #1;
            acc = in_ready;
        end
    endtask

    task automatic drive(input string txt);
        bit acc;
        for (int i = 0; i < txt.len(); i++) begin
            send_char(txt[i], (i == txt.len() - 1), 60, acc);
            if (!acc) break;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic collect(input int mode);
        int cyc = 0;
        bit done = 1'b0;
        bit stalled = 1'b0;
        logic [2:0] pk = 3'd0;
        logic [7:0] pd = 8'h00;
        while (!done && cyc < 800) begin
            @(negedge clk);
            if (stalled) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_kind", int'(out_kind), int'(pk));
                chk("stall_data", int'(out_data), int'(pd));
            end
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                got_q.push_back(tok_char(out_kind, out_data));
                if (out_kind != 3'd0) chk("nonchar_data", int'(out_data), 0);
                if (out_kind == 3'd4) done = 1'b1;
            end else if (out_valid) begin
                stalled = 1'b1; pk = out_kind; pd = out_data;
            end
            cyc++;
        end
        if (!done) chk("eof_timeout", 0, 1);
    endtask

    task automatic cmp_tokens(input string name, input string exp);
        chk($sformatf("%s_count", name), got_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            chk($sformatf("%s_tok%0d", name, i), (i < got_q.size()) ? int'(got_q[i]) : -1, int'(exp[i]));
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        got_q.delete();
        fork
            drive(v.txt);
            collect(v.mode);
        join
        repeat (2) @(negedge clk);
        in_valid = 1'b1; in_data = 8'h7A; in_last = 1'b0;
        #1;
        chk({v.name, "_done_valid"}, int'(out_valid), 0);
        chk({v.name, "_done_ready"}, int'(in_ready), 0);
        chk({v.name, "_level"}, int'(level), v.lvl);
        chk({v.name, "_err"}, int'(err), 0);
        in_valid = 1'b0;
        cmp_tokens(v.name, v.exp);
    endtask

    initial begin
        string sp60, ind15, sp64;
        bit acc;
        sp60 = ""; ind15 = "";
        for (int i = 0; i < 60; i++) sp60 = {sp60, " "};
        for (int i = 0; i < 15; i++) ind15 = {ind15, ">"};
        sp64 = {sp60, "    "};

        add_vec("assign",   "a=1\n",                   "a=1|$",        0,  0);
        add_vec("indent2",  "if\n        x",           "if|>>x|$",     2,  0);
        add_vec("dedent",   "    a\nb",                ">a|<b|$",      0,  0);
        add_vec("blanks",   "a\n\n  \nb",              "a|b|$",        0,  0);
        add_vec("stall",    "if\n        x",           "if|>>x|$",     2,  1);
        add_vec("lastsp",   "a\n  ",                   "a|$",          0,  0);
        add_vec("lastnl",   "a\n\n",                   "a|$",          0,  0);
        add_vec("multi",    "    a\n        b\nc",     ">a|>b|<<c|$",  0,  1);
        add_vec("maxlvl",   {sp60, "x"},               {ind15, "x|$"}, 15, 0);
        add_vec("bodysp",   "ab cd",                   "ab cd|$",      0,  0);

        // Reset state, checked while reset is asserted.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h61; in_last = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_kind", int'(out_kind), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ready", int'(in_ready), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // One-cycle latency from input transfer to token.
        do_reset();
        out_ready = 1'b1;
        send_char(8'h61, 1'b0, 5, acc);
        chk("lat_accept", int'(acc), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_kind", int'(out_kind), 0);
        chk("lat_data", int'(out_data), 8'h61);

        // Misaligned indentation: refused char, sticky error, cleared by reset.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_char(8'h20, 1'b0, 5, acc);
        send_char(8'h78, 1'b1, 4, acc);
        chk("mis_refused", int'(acc), 0);
        chk("mis_err", int'(err), 1);
        chk("mis_valid", int'(out_valid), 0);
        chk("mis_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("mis_rst_err", int'(err), 0);
        chk("mis_rst_level", int'(level), 0);

        // Level 16 exceeds MAX_LEVEL.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_char(sp64[i], 1'b0, 5, acc);
        send_char(8'h78, 1'b1, 4, acc);
        chk("deep_refused", int'(acc), 0);
        chk("deep_err", int'(err), 1);
        chk("deep_valid", int'(out_valid), 0);

        // Reset during ADJUST with an INDENT held by the consumer.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_char(8'h20, 1'b0, 5, acc);
        send_char(8'h61, 1'b0, 3, acc);
        chk("adj_refused", int'(acc), 0);
        @(negedge clk);
        chk("adj_held_valid", int'(out_valid), 1);
        chk("adj_held_kind", int'(out_kind), 2);
        rst = 1'b1;
        #1;
        chk("adj_rst_valid", int'(out_valid), 0);
        chk("adj_rst_level", int'(level), 0);
        do_reset();
        got_q.delete();
        fork
            drive("b");
            collect(0);
        join
        cmp_tokens("adj_after", "b|$");
        chk("adj_after_level", int'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/indent_lexer.md
INDENT_LEXER -- requirements
Module: indent_lexer

Interface
REQ-001 Parameter INDENT_WIDTH, default 4, SHALL set the spaces per indentation level.
REQ-002 Parameter MAX_LEVEL, default 15, SHALL set the deepest legal indentation level.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  in  1  SHALL mean the upstream source presents a character.
REQ-006 in_ready  out  1  SHALL mean the block accepts in_data this cycle (transfer = in_valid & in_ready).
REQ-007 in_data  in  8  SHALL be the ASCII character.
REQ-008 in_last  in  1  SHALL mark the final character of the source text.
REQ-009 out_valid  out  1  SHALL mean a token is presented.
REQ-010 out_ready  in  1  SHALL mean the downstream tokenizer takes the token (transfer = out_valid & out_ready).
REQ-011 out_kind  out  3  SHALL encode the token: 0 CHAR, 1 NEWLINE, 2 INDENT, 3 DEDENT, 4 EOF.
REQ-012 out_data  out  8  SHALL carry the character for CHAR tokens and 0x00 otherwise.
REQ-013 level  out  4  SHALL show the current committed indentation level.
REQ-014 err  out  1  SHALL be a sticky indentation-error flag.

Function
REQ-015 States SHALL be BOL (line start), ADJUST (emitting INDENT/DEDENT), BODY, DONE, ERROR.
REQ-016 All outputs SHALL be registered; one token at most per transfer; a token SHALL hold stable while out_valid & !out_ready.
REQ-017 in_ready SHALL be 0 whenever an unaccepted token is held, and in ADJUST, DONE and ERROR states.
REQ-018 BOL, space accepted: space counter SHALL increment; no token.
REQ-019 BOL, newline accepted: counter SHALL clear; no token (blank line skipped, no NEWLINE).
REQ-020 BOL, other char presented: if counter mod INDENT_WIDTH != 0 or counter/INDENT_WIDTH > MAX_LEVEL, SHALL enter ERROR without accepting it.
REQ-021 BOL, other char, target level == level: char SHALL be accepted, emitted as CHAR next cycle, state -> BODY.
REQ-022 BOL, other char, target != level: char SHALL NOT be accepted; state -> ADJUST.
REQ-023 ADJUST SHALL emit one INDENT (level+1) or DEDENT (level-1) per output transfer until level == target, then return to BOL with counter retained, so the held char passes per REQ-021.
REQ-024 level SHALL update on the output transfer of each INDENT/DEDENT.
REQ-025 BODY: spaces and non-newline chars SHALL pass through as CHAR; newline SHALL emit NEWLINE, clear counter, state -> BOL.
REQ-026 Consecutive newlines SHALL yield exactly one NEWLINE.
REQ-027 in_last on a non-newline char in BODY (or per REQ-021): after that CHAR, SHALL emit NEWLINE then EOF.
REQ-028 in_last on a newline in BODY: after NEWLINE, SHALL emit EOF.
REQ-029 in_last on a space or newline in BOL: SHALL emit EOF directly, no NEWLINE.
REQ-030 No DEDENTs SHALL be generated at end of stream; EOF only.
REQ-031 After EOF transfer state SHALL be DONE: out_valid=0, in_ready=0 until reset.
REQ-032 ERROR: err=1, out_valid=0, in_ready=0, held until reset; any pending token is discarded.
REQ-033 Latency input transfer -> corresponding token out_valid SHALL be exactly 1 cycle when out_ready is held high.

Reset
REQ-034 rst=1 SHALL immediately force state BOL, counter 0, level 0, out_valid 0, out_kind 0, out_data 0, err 0, in_ready 0; in_ready MAY rise in the first cycle after release.
REQ-035 Reset mid-line or mid-ADJUST SHALL discard all held tokens and characters.

Verification
REQ-036 "a=1\n" with last on '\n', out_ready=1 -> CHAR a, CHAR =, CHAR 1, NEWLINE, EOF; level stays 0.
REQ-037 "if\n        x" (8 spaces), last on x -> CHAR i, CHAR f, NEWLINE, INDENT, INDENT, CHAR x, NEWLINE, EOF; level=2.
REQ-038 "    a\nb", last on b -> INDENT, CHAR a, NEWLINE, DEDENT, CHAR b, NEWLINE, EOF; level=0.
REQ-039 "a\n\n  \nb" -> CHAR a, NEWLINE, CHAR b (blank and space-only lines silent).
REQ-040 "   x" (3 spaces) -> err=1, no token for x, in_ready=0; rst pulse -> err=0, level=0.
REQ-041 out_ready toggled 1-of-3 cycles on REQ-037 stimulus -> identical token sequence, no drop or duplicate, tokens stable while stalled.
